// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: DEPTH-stage pipeline of WIDTH-bit control words with per-stage
// stall/flush, bubble insertion below a stall, and a retired-instruction counter.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   in_ctrl        control word entering stage 0
//   in_valid       in_ctrl carries a real instruction
//   stall[k]       hold request for stage k (propagates to all upstream stages)
//   flush[k]       kill request for stage k (wins over stall)
//   stage_ctrl     registered control word of each stage, stage k at [k*WIDTH +: WIDTH]
//   stage_valid    registered valid bit of each stage
//   out_ctrl       final-stage control word, zero when the final stage is invalid
//   out_valid      final-stage valid bit
//   retired_count  wrapping count of valid words leaving the final stage
module ctrl_pipe_reg #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_ctrl,
    input  logic                   in_valid,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH*WIDTH-1:0] stage_ctrl,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [WIDTH-1:0]       out_ctrl,
    output logic                   out_valid,
    output logic [CNT_W-1:0]       retired_count
);

    localparam int unsigned LAST = DEPTH - 1;

    logic [DEPTH*WIDTH-1:0] ctrl_q;
    logic [DEPTH*WIDTH-1:0] ctrl_d;
    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       valid_d;
    logic [DEPTH-1:0]       estall;
    logic [CNT_W-1:0]       cnt_q;
    logic                   retire;

    // Effective stall: a stall at stage k freezes every stage upstream of it.
    always_comb begin
        logic acc;
        estall = '0;
        acc    = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc       = acc | stall[k];
            estall[k] = acc;
        end
    end

    // Next-state per stage: flush > stall(hold) > advance.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;

        if (flush[0]) begin
            valid_d[0]        = 1'b0;
            ctrl_d[0 +: WIDTH] = '0;
        end else if (!estall[0]) begin
            valid_d[0]        = in_valid;
            ctrl_d[0 +: WIDTH] = in_valid ? in_ctrl : '0;
        end

        for (int k = 1; k < DEPTH; k++) begin
            if (flush[k]) begin
                valid_d[k]             = 1'b0;
                ctrl_d[k*WIDTH +: WIDTH] = '0;
            end else if (!estall[k]) begin
                // Upstream is frozen while this stage moves on: take a bubble
                // so the held word is not duplicated.
                if (estall[k-1]) begin
                    valid_d[k]             = 1'b0;
                    ctrl_d[k*WIDTH +: WIDTH] = '0;
                end else begin
                    valid_d[k]             = valid_q[k-1];
                    ctrl_d[k*WIDTH +: WIDTH] = ctrl_q[(k-1)*WIDTH +: WIDTH];
                end
            end
        end
    end

    // A word retires when the final stage is valid and actually leaves.
    assign retire = valid_q[LAST] & ~estall[LAST] & ~flush[LAST];

    // Stage and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stage_ctrl    = ctrl_q;
    assign stage_valid   = valid_q;
    assign out_valid     = valid_q[LAST];
    assign out_ctrl      = ctrl_q[LAST*WIDTH +: WIDTH] & {WIDTH{valid_q[LAST]}};
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb_ctrl_pipe_reg: directed stimulus for ctrl_pipe_reg (WIDTH=3, DEPTH=2, CNT_W=4).
// Stimulus pushes the words expected to retire; a monitor pops them as they leave
// the final stage and tracks the expected retire count.
module tb_ctrl_pipe_reg;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 4;

    logic                   clk;
    logic                   reset;
    logic [WIDTH-1:0]       in_ctrl;
    logic                   in_valid;
    logic [DEPTH-1:0]       stall;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH*WIDTH-1:0] stage_ctrl;
    logic [DEPTH-1:0]       stage_valid;
    logic [WIDTH-1:0]       out_ctrl;
    logic                   out_valid;
    logic [CNT_W-1:0]       retired_count;

    ctrl_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_ctrl      (in_ctrl),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .stage_ctrl   (stage_ctrl),
        .stage_valid  (stage_valid),
        .out_ctrl     (out_ctrl),
        .out_valid    (out_valid),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [CNT_W-1:0] model_cnt = '0;
    logic             mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: at each negedge confirm the count so far, then predict the next edge.
    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_count", 32'(retired_count), 32'(model_cnt));
            if (!out_valid) check("mon_idle_ctrl", 32'(out_ctrl), 32'd0);
            if (reset) begin
                model_cnt = '0;
            end else if (out_valid && !stall[1] && !flush[1]) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_retire", 32'(out_ctrl), 32'hFFFF_FFFF);
                end else begin
                    check("mon_retire_word", 32'(out_ctrl), 32'(exp_q.pop_front()));
                end
                model_cnt = model_cnt + 4'd1;
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] c, input logic [1:0] st, input logic [1:0] fl);
        in_valid = v;
        in_ctrl  = c;
        stall    = st;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a valid word with no stall/flush and expect it to retire.
    task automatic issue(input logic [2:0] c);
        drive(1'b1, c, 2'b00, 2'b00);
        exp_q.push_back(c);
        tick();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'b000, 2'b00, 2'b00);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 3'b111, 2'b11, 2'b00);
        tick();
        tick();
        reset = 1'b0;
        drive(1'b0, 3'b000, 2'b00, 2'b00);
        mon_on = 1'b1;

        // Reset state
        check("rst_valid", 32'(stage_valid), 32'd0);
        check("rst_ctrl", 32'(stage_ctrl), 32'd0);
        check("rst_out", 32'({out_valid, out_ctrl}), 32'd0);
        check("rst_count", 32'(retired_count), 32'd0);

        // Flow-through, two edges of latency
        issue(3'b101);
        idle(1);
        check("flow_out_ctrl", 32'(out_ctrl), 32'b101);
        check("flow_out_valid", 32'(out_valid), 32'd1);
        idle(1);
        check("flow_drain_ctrl", 32'(out_ctrl), 32'd0);
        check("flow_count", 32'(retired_count), 32'd1);

        // Stall stage 0: A held, bubble below, B ignored while stalled
        issue(3'b011);
        drive(1'b1, 3'b110, 2'b01, 2'b00);
        tick();
        tick();
        check("stall0_hold", 32'(stage_ctrl[2:0]), 32'b011);
        check("stall0_valid", 32'(stage_valid), 32'b01);
        check("stall0_bubble", 32'(out_ctrl), 32'd0);
        check("stall0_count", 32'(retired_count), 32'd1);
        issue(3'b110);
        check("stall0_order", 32'(out_ctrl), 32'b011);
        idle(2);
        check("stall0_after", 32'(retired_count), 32'd3);

        // Stall stage 1 propagates back; input ignored
        issue(3'b001);
        issue(3'b010);
        drive(1'b1, 3'b111, 2'b10, 2'b00);
        tick();
        tick();
        check("stall1_ctrl", 32'(stage_ctrl), 32'({3'b001, 3'b010}));
        check("stall1_valid", 32'(stage_valid), 32'b11);
        check("stall1_count", 32'(retired_count), 32'd3);
        idle(2);
        check("stall1_after", 32'(retired_count), 32'd5);

        // Flush beats stall on stage 1; C is killed, D survives
        drive(1'b1, 3'b100, 2'b00, 2'b00);
        tick();
        issue(3'b011);
        drive(1'b0, 3'b000, 2'b11, 2'b10);
        tick();
        check("flush_valid", 32'(stage_valid), 32'b01);
        check("flush_ctrl", 32'(stage_ctrl), 32'({3'b000, 3'b011}));
        check("flush_count", 32'(retired_count), 32'd5);
        idle(2);
        check("flush_after", 32'(retired_count), 32'd6);

        // Wrap: 17 words through a 4-bit counter leaves 1
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("wrap_rst", 32'(retired_count), 32'd0);
        for (int i = 0; i < 17; i++) begin
            logic [31:0] v;
            v = 32'(i);
            issue(v[2:0]);
        end
        idle(2);
        check("wrap_count", 32'(retired_count), 32'd1);

        // Reset during a stall with a full pipe discards everything
        drive(1'b1, 3'b110, 2'b00, 2'b00);
        tick();
        drive(1'b1, 3'b101, 2'b00, 2'b00);
        tick();
        drive(1'b1, 3'b111, 2'b11, 2'b00);
        tick();
        check("rst_stall_full", 32'(stage_valid), 32'b11);
        reset = 1'b1;
        tick();
        check("rst_stall_valid", 32'(stage_valid), 32'd0);
        check("rst_stall_ctrl", 32'(stage_ctrl), 32'd0);
        check("rst_stall_out", 32'({out_valid, out_ctrl}), 32'd0);
        check("rst_stall_count", 32'(retired_count), 32'd0);
        reset = 1'b0;
        idle(2);
        check("rst_stall_quiet", 32'({stage_valid, retired_count}), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
